// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: the req/gnt/result bundle between the two requesters and the ALU arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH    = 16,
    parameter int ACT_BITS = 4
);
    logic                req0, req1, lock0, lock1;
    logic [ACT_BITS-1:0] act0, act1;
    logic [WIDTH-1:0]    a0, b0, a1, b1;
    logic                gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0]    rdata0, rdata1;
    modport master (
        output req0, req1, lock0, lock1, act0, act1, a0, b0, a1, b1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );
    modport slave (
        input  req0, req1, lock0, lock1, act0, act1, a0, b0, a1, b1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Define ALU_ARB_LOCK_EN to enable burst-lock grants of up to MAX_LOCK in a row.
module alu_arbiter #(
    parameter int WIDTH    = 16,
    parameter int ACT_BITS = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_arbiter_if.slave        bus,
    output logic [ACT_BITS-1:0] alu_action,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    input  logic [WIDTH-1:0]    alu_result
);
    localparam logic [ACT_BITS-1:0] PASS_A = ACT_BITS'(9);
    logic                prio, any, legal;
    logic [ACT_BITS-1:0] act_sel;
    logic [WIDTH-1:0]    a_sel, b_sel;
    always_comb begin
        bus.gnt0 = !reset && bus.req0 && (!bus.req1 || !prio);
        bus.gnt1 = !reset && bus.req1 && (!bus.req0 || prio);
        any      = bus.gnt0 || bus.gnt1;
        act_sel  = bus.gnt1 ? bus.act1 : bus.act0;
        a_sel    = bus.gnt1 ? bus.a1 : bus.a0;
        b_sel    = bus.gnt1 ? bus.b1 : bus.b0;
        // Out-of-range actions become pass-A of zero so the ALU never shows stale state
        legal      = act_sel <= PASS_A;
        alu_action = (any && legal) ? act_sel : PASS_A;
        alu_a      = (any && legal) ? a_sel : '0;
        alu_b      = (any && legal) ? b_sel : '0;
    end
`ifdef ALU_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    logic [CW-1:0] cnt, base;
    logic          keep, lock_sel;
    always_comb begin
        base     = (bus.gnt1 == prio) ? cnt : '0;
        lock_sel = bus.gnt1 ? bus.lock1 : bus.lock0;
        keep     = lock_sel && (int'(base) + 1 < MAX_LOCK);
    end
`else
    logic unused_lock;
    assign unused_lock = bus.lock0 ^ bus.lock1;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            prio        <= 1'b0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
`ifdef ALU_ARB_LOCK_EN
            cnt         <= '0;
`endif
        end else begin
            bus.rvalid0 <= bus.gnt0;
            bus.rvalid1 <= bus.gnt1;
            if (bus.gnt0) bus.rdata0 <= alu_result;
            if (bus.gnt1) bus.rdata1 <= alu_result;
`ifdef ALU_ARB_LOCK_EN
            if (any) begin
                prio <= keep ? bus.gnt1 : bus.gnt0;
                cnt  <= keep ? base + CW'(1) : '0;
            end else if (cnt != '0 && !(prio ? bus.req1 : bus.req0)) begin
                prio <= !prio;
                cnt  <= '0;
            end
`else
            if (any) prio <= bus.gnt0;
`endif
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven check of arbitration, muxing, result capture and reset.
module tb_alu_arbiter;
    localparam int W = 16, AB = 4;
    logic          clk = 1'b0, reset;
    logic [AB-1:0] alu_action;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    int checks = 0, fails = 0;
    alu_arbiter_if #(.WIDTH(W), .ACT_BITS(AB)) bus ();
    alu_arbiter #(.WIDTH(W), .ACT_BITS(AB), .MAX_LOCK(4)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .alu_action(alu_action),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
    );
    always #5 clk = ~clk;
    // Reference ALU; codes above 9 return junk to expose any leak
    always_comb begin
        alu_result = 16'hDEAD;
        case (alu_action)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd8: alu_result = alu_b << 8;
            4'd9: alu_result = alu_a;
            default: alu_result = 16'hDEAD;
        endcase
    end
    typedef struct {
        logic rst, r0, r1, l0;
        logic [3:0] c0; logic [15:0] x0, y0;
        logic [3:0] c1; logic [15:0] x1, y1;
        logic g0, g1; logic [3:0] eact; logic [15:0] ea;
        logic v0, v1; logic [15:0] d0, d1;
    } vec_t;
    vec_t v[15];
    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h", name, i, got, exp);
        end
    endtask
    task automatic drive(input vec_t t);
        reset = t.rst;
        bus.req0 = t.r0; bus.req1 = t.r1; bus.lock0 = t.l0; bus.lock1 = 1'b0;
        bus.act0 = t.c0; bus.a0 = t.x0; bus.b0 = t.y0;
        bus.act1 = t.c1; bus.a1 = t.x1; bus.b1 = t.y1;
    endtask
    logic [9:0] lock_pat;
    initial begin
        //        rst r0 r1 l0 c0  a0       b0       c1   a1       b1       g0 g1 act  alu_a    v0 v1 rd0      rd1
        v[0]  = '{1, 1, 1, 0, 0, 16'h3,   16'h4,   0,   16'h0,   16'h0,   0, 0, 9, 16'h0,    0, 0, 16'h0,   16'h0};
        v[1]  = '{1, 1, 1, 0, 0, 16'h3,   16'h4,   0,   16'h0,   16'h0,   0, 0, 9, 16'h0,    0, 0, 16'h0,   16'h0};
        v[2]  = '{0, 1, 0, 0, 0, 16'h3,   16'h4,   0,   16'h0,   16'h0,   1, 0, 0, 16'h3,    0, 0, 16'h0,   16'h0};
        v[3]  = '{0, 0, 0, 0, 0, 16'h0,   16'h0,   0,   16'h0,   16'h0,   0, 0, 9, 16'h0,    1, 0, 16'h7,   16'h0};
        v[4]  = '{0, 0, 1, 0, 0, 16'h0,   16'h0,   9,   16'hBEEF,16'h0,   0, 1, 9, 16'hBEEF, 0, 0, 16'h7,   16'h0};
        v[5]  = '{0, 0, 1, 0, 0, 16'h0,   16'h0,   4'hC,16'h1234,16'h55,  0, 1, 9, 16'h0,    0, 1, 16'h7,   16'hBEEF};
        v[6]  = '{0, 1, 1, 0, 1, 16'h5,   16'h3,   8,   16'h0,   16'h12,  1, 0, 1, 16'h5,    0, 1, 16'h7,   16'h0};
        v[7]  = '{0, 1, 1, 0, 1, 16'h5,   16'h3,   8,   16'h0,   16'h12,  0, 1, 8, 16'h0,    1, 0, 16'h2,   16'h0};
        v[8]  = '{0, 1, 1, 0, 1, 16'h5,   16'h3,   8,   16'h0,   16'h12,  1, 0, 1, 16'h5,    0, 1, 16'h2,   16'h1200};
        v[9]  = '{0, 1, 1, 0, 1, 16'h5,   16'h3,   8,   16'h0,   16'h12,  0, 1, 8, 16'h0,    1, 0, 16'h2,   16'h1200};
        v[10] = '{0, 1, 0, 0, 4, 16'h00FF,16'h0F0F,0,   16'h0,   16'h0,   1, 0, 4, 16'h00FF, 0, 1, 16'h2,   16'h1200};
        v[11] = '{1, 1, 1, 0, 0, 16'h3,   16'h4,   0,   16'h0,   16'h0,   0, 0, 9, 16'h0,    1, 0, 16'h0FF0,16'h1200};
        v[12] = '{0, 0, 0, 0, 0, 16'h0,   16'h0,   0,   16'h0,   16'h0,   0, 0, 9, 16'h0,    0, 0, 16'h0,   16'h0};
        v[13] = '{0, 1, 1, 0, 0, 16'h1,   16'h1,   1,   16'h9,   16'h4,   1, 0, 0, 16'h1,    0, 0, 16'h0,   16'h0};
        v[14] = '{0, 0, 0, 0, 0, 16'h0,   16'h0,   0,   16'h0,   16'h0,   0, 0, 9, 16'h0,    1, 0, 16'h2,   16'h0};
        drive(v[0]);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 drive(v[i]);
            #4;
            chk("gnt0", i, 32'(bus.gnt0), 32'(v[i].g0));
            chk("gnt1", i, 32'(bus.gnt1), 32'(v[i].g1));
            chk("alu_action", i, 32'(alu_action), 32'(v[i].eact));
            chk("alu_a", i, 32'(alu_a), 32'(v[i].ea));
            chk("rvalid0", i, 32'(bus.rvalid0), 32'(v[i].v0));
            chk("rvalid1", i, 32'(bus.rvalid1), 32'(v[i].v1));
            chk("rdata0", i, 32'(bus.rdata0), 32'(v[i].d0));
            chk("rdata1", i, 32'(bus.rdata1), 32'(v[i].d1));
        end
`ifdef ALU_ARB_LOCK_EN
        lock_pat = 10'b0111101111;
`else
        lock_pat = 10'b0101010101;
`endif
        @(posedge clk);
        #1 reset = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.act0 = 4'd0; bus.a0 = 16'h1; bus.b0 = 16'h1;
        bus.req1 = 1'b1; bus.act1 = 4'd1; bus.a1 = 16'h9; bus.b1 = 16'h4;
        for (int k = 0; k < 10; k++) begin
            #4;
            chk("lock_gnt0", k, 32'(bus.gnt0), 32'(lock_pat[k]));
            chk("lock_gnt1", k, 32'(bus.gnt1), 32'(!lock_pat[k]));
            if (k > 0) begin
                chk("lock_rvalid0", k, 32'(bus.rvalid0), 32'(lock_pat[k-1]));
                chk("lock_rvalid1", k, 32'(bus.rvalid1), 32'(!lock_pat[k-1]));
                if (lock_pat[k-1]) chk("lock_rdata0", k, 32'(bus.rdata0), 32'h2);
                else chk("lock_rdata1", k, 32'(bus.rdata1), 32'h5);
            end
            @(posedge clk);
            #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters, e.g. the EX stage and the branch/jump target path, using a per-requester req/gnt handshake with round-robin fairness. A granted request drives the ALU in the grant cycle. The result is registered and returned to the winner one cycle later with a one-cycle valid pulse. The block sits between the pipeline control and the `alu` instance and owns the ALU's `ALUAction`, `A` and `B` inputs.

## Interface
- `WIDTH`, default 16: data width; matches `WORD_SIZE`.
- `ACT_BITS`, default 4: action width; matches `ALU_ACTION_BITS`.
- `MAX_LOCK`, default 4: maximum consecutive locked grants (used only with `ALU_ARB_LOCK_EN`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  request from requester 0 / 1.
- `act0` / `act1`  in  ACT_BITS  requested ALU action code.
- `a0`, `b0` / `a1`, `b1`  in  WIDTH  operands.
- `lock0` / `lock1`  in  1  burst-lock request; ignored unless `ALU_ARB_LOCK_EN` is defined.
- `gnt0` / `gnt1`  out  1  grant, combinational, at most one high per cycle.
- `rvalid0` / `rvalid1`  out  1  registered one-cycle result-valid pulse.
- `rdata0` / `rdata1`  out  WIDTH  registered result; holds its value until that requester's next rvalid.
- `alu_action`  out  ACT_BITS  drives `alu.ALUAction`.
- `alu_a`, `alu_b`  out  WIDTH  drive `alu.A` and `alu.B`.
- `alu_result`  in  WIDTH  from `alu.result`.

## Operation
- State:
  - `prio`: 1 bit, the requester that wins a tie.
  - Response registers: `rvalid0/1`, `rdata0/1`.
  - Lock counter: only with the macro.
- Arbitration, evaluated every cycle while `reset`=0:
  - Only reqX high: gntX=1.
  - Both high: the `prio` requester wins.
  - Neither high: no grant.
- After a grant to X, `prio` becomes the other requester. With no grant, `prio` is unchanged.
- Mux:
  - Granted requester: `alu_action`/`alu_a`/`alu_b` = actX/aX/bX.
  - Idle: action 9 (pass A), A=0, B=0.
- Legal action codes are 0–9. For a granted action greater than 9, the block drives action 9 with A=0, so rdata=0. The ALU's stale-latch behaviour is never exposed.
- Result capture: at the edge that ends a grant cycle for X, rdataX ← alu_result and rvalidX ← 1. The other requester's rvalid ← 0.
- Handshake:
  - The requester holds reqX, actX, aX and bX stable until it samples gntX=1.
  - It may deassert or change them in the cycle after the grant.
  - Back-to-back requests are accepted every cycle.
- Reset, synchronous:
  - gnt0/1=0 while `reset`=1, regardless of req.
  - rvalid0/1=0, rdata0/1=0, `prio`=0, lock counter=0.
  - ALU outputs take their idle values.
  - A grant cycle coincident with reset is discarded: no rvalid follows.

## Timing
- Grant latency: 0 cycles (combinational from req and `prio`).
- Result latency: 1 cycle. rvalidX is high in cycle N+1 for a grant in cycle N.
- Throughput: one operation per cycle total.
- Worst-case wait without lock: 1 cycle while the other requester also requests continuously.
- The combinational path req→gnt→mux→alu→alu_result ends at the rdata registers; no path feeds back into the requesters within the same cycle.

## Configuration
- `ALU_ARB_LOCK_EN` defined:
  - If granted requester X has lockX=1 in its grant cycle, X keeps priority next cycle.
  - The lock counter increments per consecutive locked grant to X.
  - When the counter reaches `MAX_LOCK`, or X drops lockX or reqX, `prio` passes to the other requester and the counter clears.
  - The counter also clears on any grant to the other requester.
- `ALU_ARB_LOCK_EN` undefined: `lock0`/`lock1` are ignored, no counter is built, and arbitration is pure alternate round-robin.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with req0=req1=1 → gnt0=gnt1=0, rvalid=0, rdata0=rdata1=0x0000, alu_action=9.
- Single request: req0=1, act0=0, a0=0x0003, b0=0x0004 for one cycle → gnt0=1 that cycle; next cycle rvalid0=1, rdata0=0x0007, rvalid1=0.
- Contention: req0 and req1 held 4 cycles, with act0=1, a0=5, b0=3 and act1=8, b1=0x0012 → grants 0,1,0,1; rdata0=0x0002 and rdata1=0x1200 on alternating rvalid pulses.
- Illegal action: req1=1, act1=0xC, a1=0x1234 → gnt1=1, ALU driven with action 9 and A=0; next cycle rvalid1=1, rdata1=0x0000.
- Lock:
  - With `ALU_ARB_LOCK_EN`: req0=lock0=1 and req1=1 held 10 cycles → gnt0 ×4, gnt1 ×1, gnt0 ×4, gnt1 ×1.
  - Without the macro: grants alternate 0,1,0,1.
- Reset mid-operation: grant to requester 0 in cycle N with `reset`=1 in cycle N → rvalid0=0 in cycle N+1, `prio`=0, rdata0=0x0000.
